// File: rtl/muldiv_iter_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The master drives a request; the slave (the unit) returns busy/valid/result.
interface muldiv_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_rs1;
    logic [WIDTH-1:0] i_rs2;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;
    logic             o_div_zero;

    modport master (
        output i_start, i_op, i_rs1, i_rs2,
        input  o_busy, o_valid, o_result, o_div_zero
    );

    modport slave (
        input  i_start, i_op, i_rs1, i_rs2,
        output o_busy, o_valid, o_result, o_div_zero
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// one shared adder per iteration, sign handled by magnitude + final correction.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    muldiv_iter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]         state, state_nxt;
    logic [2:0]         op;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   rem, quo;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
    logic               busy, valid, div_zero;
    logic [WIDTH-1:0]   result;

    // Request decode: operand signedness, magnitudes and the divide bypass cases
    logic             a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic             is_div_in, div_zero_in, ovf_in, bypass_in;
    logic [WIDTH-1:0] bypass_res;

    always_comb begin
        a_sgn_in    = (bus.i_op == 3'b001) || (bus.i_op == 3'b010) ||
                      (bus.i_op == 3'b100) || (bus.i_op == 3'b110);
        b_sgn_in    = (bus.i_op == 3'b001) || (bus.i_op == 3'b100) ||
                      (bus.i_op == 3'b110);
        a_neg_in    = a_sgn_in & bus.i_rs1[WIDTH-1];
        b_neg_in    = b_sgn_in & bus.i_rs2[WIDTH-1];
        a_mag_in    = a_neg_in ? ((~bus.i_rs1) + WIDTH'(1)) : bus.i_rs1;
        b_mag_in    = b_neg_in ? ((~bus.i_rs2) + WIDTH'(1)) : bus.i_rs2;
        is_div_in   = bus.i_op[2];
        div_zero_in = (bus.i_rs2 == '0);
        ovf_in      = bus.i_op[2] && !bus.i_op[0] &&
                      (bus.i_rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.i_rs2 == '1);
        bypass_in   = is_div_in && (div_zero_in || ovf_in);
        bypass_res  = '0;
        if (div_zero_in) begin
            bypass_res = bus.i_op[1] ? bus.i_rs1 : '1;
        end else begin
            bypass_res = bus.i_op[1] ? '0 : bus.i_rs1;
        end
    end

    // Shared adder: accumulate multiplicand, or trial-subtract the divisor
    logic [WIDTH+1:0]   add_x, add_y, add_sum;
    logic               add_cin, sub_ok;
    logic [2*WIDTH-1:0] prod_nxt, prod_fin;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt, quo_fin, rem_fin, fin_res;

    always_comb begin
        add_x   = {2'b00, prod[2*WIDTH-1:WIDTH]};
        add_y   = {2'b00, a_mag};
        add_cin = 1'b0;
        if (op[2]) begin
            add_x   = {1'b0, rem, quo[WIDTH-1]};
            add_y   = ~{2'b00, b_mag};
            add_cin = 1'b1;
        end
        add_sum  = add_x + add_y + (WIDTH+2)'(add_cin);
        sub_ok   = !add_sum[WIDTH+1];
        prod_nxt = prod[0] ? {add_sum[WIDTH:0], prod[WIDTH-1:1]}
                           : {1'b0, prod[2*WIDTH-1:1]};
        rem_nxt  = sub_ok ? add_sum[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo_nxt  = {quo[WIDTH-2:0], sub_ok};
        prod_fin = (neg_a ^ neg_b) ? ((~prod_nxt) + (2*WIDTH)'(1)) : prod_nxt;
        quo_fin  = (neg_a ^ neg_b) ? ((~quo_nxt) + WIDTH'(1)) : quo_nxt;
        rem_fin  = neg_a ? ((~rem_nxt) + WIDTH'(1)) : rem_nxt;
        case (op)
            3'b000:                  fin_res = prod_fin[WIDTH-1:0];
            3'b001, 3'b010, 3'b011:  fin_res = prod_fin[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:          fin_res = quo_fin;
            default:                 fin_res = rem_fin;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.i_start) state_nxt = bypass_in ? DONE : CALC;
            CALC: if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration registers and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op       <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            rem      <= '0;
            quo      <= '0;
            prod     <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            result   <= '0;
            div_zero <= 1'b0;
        end else begin
            busy  <= (state_nxt != IDLE);
            valid <= (state_nxt == DONE);
            if (state == IDLE && bus.i_start) begin
                op    <= bus.i_op;
                neg_a <= a_neg_in;
                neg_b <= b_neg_in;
                a_mag <= a_mag_in;
                b_mag <= b_mag_in;
                prod  <= {{WIDTH{1'b0}}, b_mag_in};
                rem   <= '0;
                quo   <= a_mag_in;
                cnt   <= CNT_W'(WIDTH);
                if (bypass_in) begin
                    result   <= bypass_res;
                    div_zero <= div_zero_in;
                end
            end else if (state == CALC) begin
                cnt <= cnt - CNT_W'(1);
                if (op[2]) begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                end else begin
                    prod <= prod_nxt;
                end
                if (cnt == CNT_W'(1)) begin
                    result   <= fin_res;
                    div_zero <= 1'b0;
                end
            end
        end
    end

    assign bus.o_busy     = busy;
    assign bus.o_valid    = valid;
    assign bus.o_result   = result;
    assign bus.o_div_zero = div_zero;
endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: 32-bit and 8-bit instances, arithmetic reference model
// with per-cycle output comparison plus directed literal vectors.
module tb_muldiv_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_iter_if #(.WIDTH(32)) b32();
    muldiv_iter_if #(.WIDTH(8))  b8();

    muldiv_iter #(.WIDTH(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(b32));
    muldiv_iter #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst(rst), .bus(b8));

    int n_tests = 0;
    int n_fail  = 0;

    logic        st[2], ob[2], ov[2], odz[2];
    logic [2:0]  opv[2];
    logic [31:0] av[2], bv[2], ores[2];

    assign st[0] = b32.i_start;   assign st[1] = b8.i_start;
    assign opv[0] = b32.i_op;     assign opv[1] = b8.i_op;
    assign av[0] = b32.i_rs1;     assign av[1] = 32'(b8.i_rs1);
    assign bv[0] = b32.i_rs2;     assign bv[1] = 32'(b8.i_rs2);
    assign ob[0] = b32.o_busy;    assign ob[1] = b8.o_busy;
    assign ov[0] = b32.o_valid;   assign ov[1] = b8.o_valid;
    assign ores[0] = b32.o_result; assign ores[1] = 32'(b8.o_result);
    assign odz[0] = b32.o_div_zero; assign odz[1] = b8.o_div_zero;

    function automatic int unsigned wd(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    // RV32M reference at width w: returns {bypass, div_zero, result}
    function automatic logic [33:0] ref_calc(input int unsigned w, input logic [2:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [127:0] ea, eb, p, q, r;
        logic [31:0] mask, am, bm, res;
        logic sa, sb, dz, byp;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am = a & mask;
        bm = b & mask;
        sa = op inside {3'd1, 3'd2, 3'd4, 3'd6};
        sb = op inside {3'd1, 3'd4, 3'd6};
        ea = 128'(am);
        eb = 128'(bm);
        if (sa && am[w-1]) ea = ea - (128'sd1 << w);
        if (sb && bm[w-1]) eb = eb - (128'sd1 << w);
        dz = 1'b0;
        byp = 1'b0;
        if (!op[2]) begin
            p = ea * eb;
            res = (op == 3'd0) ? 32'(p) : 32'(p >> w);
        end else if (bm == 32'd0) begin
            dz = 1'b1;
            byp = 1'b1;
            res = op[1] ? am : mask;
        end else if (sa && ea == -(128'sd1 << (w - 1)) && eb == -128'sd1) begin
            byp = 1'b1;
            res = op[1] ? 32'd0 : am;
        end else begin
            q = ea / eb;
            r = ea % eb;
            res = op[1] ? 32'(r) : 32'(q);
        end
        return {byp, dz, res & mask};
    endfunction

    function automatic logic [31:0] f_res(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [33:0] t;
        t = ref_calc(wd(i), op, a, b);
        return t[31:0];
    endfunction
    function automatic logic f_dz(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [33:0] t;
        t = ref_calc(wd(i), op, a, b);
        return t[32];
    endfunction
    function automatic int f_lat(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [33:0] t;
        t = ref_calc(wd(i), op, a, b);
        return t[33] ? 1 : int'(wd(i)) + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: k = cycle index since the accepted start edge (0 when idle)
    int          k[2], lat[2];
    logic [31:0] held[2], pend[2];
    logic        edz[2], pdz[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                k[i] <= 0; lat[i] <= 0; held[i] <= '0; pend[i] <= '0;
                edz[i] <= 1'b0; pdz[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (k[i] == 0) begin
                    if (st[i] === 1'b1) begin
                        k[i]    <= 1;
                        lat[i]  <= f_lat(i, opv[i], av[i], bv[i]);
                        pend[i] <= f_res(i, opv[i], av[i], bv[i]);
                        pdz[i]  <= f_dz(i, opv[i], av[i], bv[i]);
                        if (f_lat(i, opv[i], av[i], bv[i]) == 1) begin
                            held[i] <= f_res(i, opv[i], av[i], bv[i]);
                            edz[i]  <= f_dz(i, opv[i], av[i], bv[i]);
                        end
                    end
                end else if (k[i] == lat[i]) begin
                    k[i] <= 0;
                end else begin
                    k[i] <= k[i] + 1;
                    if (k[i] + 1 == lat[i]) begin
                        held[i] <= pend[i];
                        edz[i]  <= pdz[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("w%0d busy", wd(i)), 32'(ob[i]), 32'(k[i] != 0));
            check($sformatf("w%0d valid", wd(i)), 32'(ov[i]), 32'(k[i] != 0 && k[i] == lat[i]));
            check($sformatf("w%0d result", wd(i)), ores[i], held[i]);
            if (k[i] != 0 && k[i] == lat[i])
                check($sformatf("w%0d div_zero", wd(i)), 32'(odz[i]), 32'(edz[i]));
        end
    end

    task automatic drive(input int i, input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin
            b32.i_start = s; b32.i_op = op; b32.i_rs1 = a; b32.i_rs2 = b;
        end else begin
            b8.i_start = s; b8.i_op = op; b8.i_rs1 = a[7:0]; b8.i_rs2 = b[7:0];
        end
    endtask

    // One request; cyc = cycle of o_valid after the start edge (-1 on timeout)
    task automatic run_op(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic dz, output int cyc, output int bcyc);
        @(negedge clk);
        drive(i, 1'b1, op, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(i, 1'b0, op, a, b);
        cyc = -1; bcyc = 0; res = '0; dz = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            if (ob[i]) bcyc++;
            if (ov[i]) begin
                cyc = c; res = ores[i]; dz = odz[i];
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_vec(input string name, input int i, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic exp_dz, input int exp_lat);
        logic [31:0] res; logic dz; int cyc, bcyc;
        run_op(i, op, a, b, res, dz, cyc, bcyc);
        check({name, " result"}, res, exp);
        check({name, " div_zero"}, 32'(dz), 32'(exp_dz));
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res, a, b;
        logic dz;
        int cyc, bcyc, nv;
        rst = 1'b1;
        drive(0, 1'b0, 3'd0, '0, '0);
        drive(1, 1'b0, 3'd0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        check("reset busy", 32'(ob[0]), 32'd0);
        check("reset valid", 32'(ov[0]), 32'd0);
        check("reset result", ores[0], 32'd0);
        check("reset div_zero", 32'(odz[0]), 32'd0);
        #2 rst = 1'b0;

        run_op(0, 3'b000, 32'd7, 32'hFFFF_FFFD, res, dz, cyc, bcyc);
        check("MUL result", res, 32'hFFFF_FFEB);
        check("MUL latency", 32'(cyc), 32'd33);
        check("MUL busy cycles", 32'(bcyc), 32'd33);
        do_vec("MULH",   0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        do_vec("MULHU",  0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        do_vec("MULHSU", 0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
        do_vec("DIV",    0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        do_vec("REM",    0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        do_vec("DIVU",   0, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        do_vec("REMU",   0, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        do_vec("DIVU0",  0, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        do_vec("REM0",   0, 3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1, 1);
        do_vec("DIVOVF", 0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        do_vec("REMOVF", 0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        do_vec("MUL after bypass", 0, 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 33);

        // Start while busy is ignored
        @(negedge clk);
        drive(0, 1'b1, 3'b000, 32'd3, 32'd4);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 3'b000, 32'd3, 32'd4);
        nv = 0; res = '0;
        for (int c = 1; c <= 45; c++) begin
            if (ov[0]) begin nv++; res = ores[0]; end
            if (c == 10) drive(0, 1'b1, 3'b100, 32'd9, 32'd3);
            else drive(0, 1'b0, 3'b100, 32'd9, 32'd3);
            @(negedge clk);
        end
        check("busy-start valid count", 32'(nv), 32'd1);
        check("busy-start result", res, 32'd12);

        // Reset mid-operation aborts the request
        drive(0, 1'b1, 3'b100, 32'd100, 32'd7);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 3'b100, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(ob[0]), 32'd0);
        check("abort valid", 32'(ov[0]), 32'd0);
        check("abort result", ores[0], 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ov[0]) nv++;
        end
        check("abort valid count", 32'(nv), 32'd0);
        do_vec("DIVU after abort", 0, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33);

        // 8-bit instance
        do_vec("W8 DIV",    1, 3'b100, 32'hF9, 32'h02, 32'hFD, 1'b0, 9);
        do_vec("W8 MULHU",  1, 3'b011, 32'hFF, 32'hFF, 32'hFE, 1'b0, 9);
        do_vec("W8 REMOVF", 1, 3'b110, 32'h80, 32'hFF, 32'h00, 1'b0, 1);
        for (int op = 0; op < 8; op++) begin
            for (int n = 0; n < 100; n++) begin
                a = $urandom;
                b = $urandom;
                if (n % 8 == 3) b = 32'd0;
                if (n % 8 == 5) begin a = 32'h80; b = 32'hFF; end
                run_op(1, 3'(op), a, b, res, dz, cyc, bcyc);
                check($sformatf("W8 op%0d latency", op), 32'(cyc), 32'(f_lat(1, 3'(op), a, b)));
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative, parametrised multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Extends the combinational adder/ALU datapath with a multi-cycle engine.
- Sits beside the ALU in the execute stage; the control unit stalls the PC while o_busy is high.
- Uses one shared WIDTH-bit adder/subtractor per iteration: radix-2 shift-add for multiply, restoring division for divide.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  request pulse; sampled only in IDLE.
- i_op  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1  input  WIDTH  operand A (multiplicand or dividend).
- i_rs2  input  WIDTH  operand B (multiplier or divisor).
- o_busy  output  1  high while in CALC or DONE.
- o_valid  output  1  one-cycle pulse; o_result is valid in that cycle.
- o_result  output  WIDTH  result; holds its value until the next o_valid.
- o_div_zero  output  1  qualified by o_valid; set when a divide or remainder op had a zero divisor.

Behaviour:
- The clock port is i_clk. Reset is i_rst, asynchronous and active-high.
- Reset values: state=IDLE, o_busy=0, o_valid=0, o_result=0, o_div_zero=0, all internal registers 0.
- Reset asserted mid-operation aborts immediately. No o_valid is produced for the aborted request.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE + i_start at edge N:
  - Latch i_op and both operands.
  - Record the operand signs per op: MULH/DIV/REM treat both signed; MULHSU treats A signed and B unsigned; others are unsigned.
  - Store magnitudes of the signed operands.
  - Load counter = WIDTH and go to CALC.
- Special divides bypass CALC and go directly to DONE at edge N, so o_valid is high in the cycle after edge N:
  - Divisor == 0: quotient = all ones; remainder = A; o_div_zero=1.
  - Signed overflow (A = most-negative, B = -1, ops DIV/REM): quotient = A; remainder = 0.
- CALC: one iteration per edge, counter decrements, and the state leaves CALC when the counter reaches 0. After WIDTH iterations the state is DONE at edge N+WIDTH.
  - Multiply: 2*WIDTH-bit product register. If the multiplier LSB is set, add the multiplicand to the high half, then shift right by 1 including the carry.
  - Divide: shift the remainder:quotient pair left by 1 and trial-subtract the divisor. If the result is non-negative, commit it and set the quotient LSB.
- DONE (lasts one cycle): o_valid=1. o_result is registered at entry to DONE as follows:
  - MUL: low WIDTH bits of the sign-corrected product.
  - MULH/MULHSU/MULHU: high WIDTH bits of the sign-corrected product.
  - DIV/DIVU: quotient, negated if the operand signs differ (signed ops only).
  - REM/REMU: remainder, taking the dividend's sign (signed ops only).
- Latency: normal ops give o_valid exactly WIDTH+1 cycles after the start edge; the bypass case gives 1 cycle.
- i_start while o_busy=1 is ignored. No queueing; operand changes during CALC have no effect.
- i_start in the DONE cycle is ignored. A new request is accepted only in the following IDLE cycle, so the minimum request spacing is WIDTH+2 cycles.
- o_div_zero is 0 for all multiply ops and for non-zero divisors.
- MUL gives the same result for signed and unsigned operands (low half of the product).

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> 0xFFFFFFEB, o_valid exactly 33 cycles after the start edge, o_busy high for 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF with o_div_zero=1, 1-cycle latency; REM 0x12345678 / 0 -> 0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start MUL 3 x 4, pulse i_start with DIV 9 / 3 at cycle 10 -> only one o_valid, result 12; then assert i_rst at cycle 5 of a new DIV -> outputs 0 immediately, no o_valid, and the next request completes normally.
- WIDTH=8 instance, 100 random ops per opcode -> results match the RV32M-defined reference model truncated to 8 bits, with 9-cycle latency.
